// File: rtl/accumulator_sequencer.sv
// Sequencer and accumulator driving an external latched add/subtract ALU over a shared result bus.
// Optional signed-overflow detection is built when the ACC_OVERFLOW_EN macro is defined.
module accumulator_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        OP_VALID,
  output logic        OP_READY,
  input  logic [1:0]  OP_CODE,
  input  logic [31:0] S,
  output logic [31:0] ALU_A,
  output logic [31:0] ALU_B,
  output logic        ALU_SUB,
  output logic        ALU_LE,
  output logic        ALU_OE_n,
  input  logic [31:0] ALU_RESULT,
  output logic [31:0] ACC,
  output logic        ACC_NEG,
  output logic        DONE,
  output logic        OVERFLOW
);

  typedef enum logic [2:0] {IDLE, SETTLE, LATCH, DRIVE, CAPTURE} state_e;
  typedef enum logic [1:0] {OP_LDN = 2'b00, OP_SUB = 2'b01, OP_ADD = 2'b10, OP_NOP = 2'b11} op_e;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic        alu_sub_q, alu_sub_d;
  logic [31:0] acc_q, acc_d;
  logic        done_q, done_d;
  op_e         op;

  assign op = op_e'(OP_CODE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sub_d = alu_sub_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (OP_VALID) begin
          if (op == OP_NOP) begin
            done_d = 1'b1;
          end else begin
            alu_a_d   = (op == OP_LDN) ? 32'd0 : acc_q;
            alu_b_d   = S;
            alu_sub_d = (op != OP_ADD);
            cnt_d     = SETTLE_LOAD;
            state_d   = SETTLE;
          end
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = LATCH;
      end
      LATCH:   state_d = DRIVE;
      DRIVE:   state_d = CAPTURE;
      CAPTURE: begin
        acc_d   = ALU_RESULT;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      alu_a_q   <= 32'd0;
      alu_b_q   <= 32'd0;
      alu_sub_q <= 1'b0;
      acc_q     <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sub_q <= alu_sub_d;
      acc_q     <= acc_d;
      done_q    <= done_d;
    end
  end

`ifdef ACC_OVERFLOW_EN
  logic ovf_q, ovf_d, ovf_hit;

  // ALU_A is zero for LDN, so the subtract rule also covers LDN of 0x80000000.
  assign ovf_hit = alu_sub_q
                 ? ((alu_a_q[31] != alu_b_q[31]) && (ALU_RESULT[31] != alu_a_q[31]))
                 : ((alu_a_q[31] == alu_b_q[31]) && (ALU_RESULT[31] != alu_a_q[31]));

  always_comb begin
    ovf_d = ovf_q | ((state_q == CAPTURE) && ovf_hit);
  end

  always_ff @(posedge CLK) begin
    if (RESET) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign OVERFLOW = ovf_q;
`else
  assign OVERFLOW = 1'b0;
`endif

  assign OP_READY = (state_q == IDLE);
  assign ALU_LE   = (state_q == LATCH);
  assign ALU_OE_n = !((state_q == DRIVE) || (state_q == CAPTURE));
  assign ALU_A    = alu_a_q;
  assign ALU_B    = alu_b_q;
  assign ALU_SUB  = alu_sub_q;
  assign ACC      = acc_q;
  assign ACC_NEG  = acc_q[31];
  assign DONE     = done_q;

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Randomized bench for accumulator_sequencer with a behavioural ALU on the bus and an arithmetic reference model.
module tb_accumulator_sequencer;
  localparam int N = 4;
  localparam logic [1:0] LDN = 2'b00, SUB = 2'b01, ADD = 2'b10, NOP = 2'b11;
`ifdef ACC_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, OP_VALID;
  logic [1:0]  OP_CODE;
  logic [31:0] S;
  logic        OP_READY, ALU_SUB, ALU_LE, ALU_OE_n, ACC_NEG, DONE, OVERFLOW;
  logic [31:0] ALU_A, ALU_B, ALU_RESULT, ACC;

  accumulator_sequencer #(.SETTLE_CYCLES(N)) dut (
    .CLK(CLK), .RESET(RESET), .OP_VALID(OP_VALID), .OP_READY(OP_READY),
    .OP_CODE(OP_CODE), .S(S), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_SUB(ALU_SUB),
    .ALU_LE(ALU_LE), .ALU_OE_n(ALU_OE_n), .ALU_RESULT(ALU_RESULT), .ACC(ACC),
    .ACC_NEG(ACC_NEG), .DONE(DONE), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // External ALU: latches A +/- B while LE is high, drives the bus only while OE_n is low.
  logic [31:0] alu_lat = 32'd0;
  always @(posedge CLK) if (ALU_LE) alu_lat <= ALU_SUB ? (ALU_A - ALU_B) : (ALU_A + ALU_B);
  assign ALU_RESULT = ALU_OE_n ? 32'hA5A5_A5A5 : alu_lat;

  logic [31:0] m_acc = 32'd0;
  bit          m_ovf = 1'b0;
  int          n_pass = 0;
  int          n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference semantics: exact signed arithmetic, then wrap to 32 bits.
  task automatic model_op(input logic [1:0] op, input logic [31:0] s);
    longint a, b, r;
    a = longint'($signed(m_acc));
    b = longint'($signed(s));
    case (op)
      LDN:     r = -b;
      SUB:     r = a - b;
      ADD:     r = a + b;
      default: return;
    endcase
    if (OVF_EN && (r > 64'sd2147483647 || r < -64'sd2147483648)) m_ovf = 1'b1;
    m_acc = r[31:0];
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_acc"},   ACC, 32'd0);
    check({tag, "_oe_n"},  ALU_OE_n, 1'b1);
    check({tag, "_le"},    ALU_LE, 1'b0);
    check({tag, "_ready"}, OP_READY, 1'b1);
    check({tag, "_done"},  DONE, 1'b0);
    check({tag, "_ovf"},   OVERFLOW, 1'b0);
    check({tag, "_alu_a"}, ALU_A, 32'd0);
    check({tag, "_alu_b"}, ALU_B, 32'd0);
    check({tag, "_sub"},   ALU_SUB, 1'b0);
  endtask

  // Called on a falling edge; returns on the falling edge of the DONE cycle (or after an abort).
  task automatic run_op(input logic [1:0] op, input logic [31:0] s, input int abort_at);
    int budget = 0;
    logic [31:0] exp_a, le_m, oe_m, done_m;
    bit stable = 1'b1;
    bit done_seen = 1'b0;
    while (!OP_READY && budget < 64) begin
      @(negedge CLK);
      budget++;
    end
    if (!OP_READY) check("ready_timeout", OP_READY, 1'b1);
    OP_VALID = 1'b1; OP_CODE = op; S = s;
    exp_a = (op == LDN) ? 32'd0 : m_acc;
    @(negedge CLK);
    OP_VALID = 1'b0; OP_CODE = 2'($urandom); S = $urandom;
    if (op == NOP) begin
      check("nop_done", DONE, 1'b1);
      check("nop_acc", ACC, m_acc);
      check("nop_ready", OP_READY, 1'b1);
      return;
    end
    check("alu_a", ALU_A, exp_a);
    check("alu_b", ALU_B, s);
    check("alu_sub", ALU_SUB, (op != ADD));
    le_m = 0; oe_m = 0; done_m = 0;
    for (int k = 1; k <= N + 4; k++) begin
      le_m[k]   = ALU_LE;
      oe_m[k]   = !ALU_OE_n;
      done_m[k] = DONE;
      if (k <= N + 3 && (ALU_A !== exp_a || ALU_B !== s || ALU_SUB !== (op != ADD))) stable = 1'b0;
      if (k == abort_at) begin
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        m_acc = 32'd0; m_ovf = 1'b0;
        check_reset_state("abort");
        for (int j = 0; j < N + 6; j++) begin
          if (DONE || ALU_LE || !ALU_OE_n) done_seen = 1'b1;
          @(negedge CLK);
        end
        check("abort_quiet", done_seen, 1'b0);
        return;
      end
      if (k < N + 4) @(negedge CLK);
    end
    model_op(op, s);
    check("le_timing", le_m, 32'd1 << (N + 1));
    check("oe_timing", oe_m, (32'd1 << (N + 2)) | (32'd1 << (N + 3)));
    check("done_timing", done_m, 32'd1 << (N + 4));
    check("operands_stable", stable, 1'b1);
    check("acc", ACC, m_acc);
    check("acc_neg", ACC_NEG, m_acc[31]);
    check("overflow", OVERFLOW, m_ovf);
    check("ready_after", OP_READY, 1'b1);
  endtask

  initial begin
    bit quiet;
    logic [31:0] s;
    RESET = 1'b1; OP_VALID = 1'b0; OP_CODE = 2'b00; S = 32'd0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_state("reset");

    run_op(LDN, 32'd5, 0);
    check("ldn5_acc", ACC, 32'hFFFF_FFFB);
    run_op(SUB, 32'hFFFF_FFF6, 0);
    check("sub_acc", ACC, 32'd5);
    run_op(ADD, 32'd3, 0);
    check("b2b_acc", ACC, 32'd8);

    run_op(SUB, 32'd1, N + 1);

    run_op(LDN, 32'h8000_0000, 0);
    check("ldn_min_acc", ACC, 32'h8000_0000);
    check("ldn_min_ovf", OVERFLOW, OVF_EN);
    run_op(ADD, 32'd1, 0);
    check("ovf_sticky", OVERFLOW, OVF_EN);

    // Reset wins over a simultaneous request.
    RESET = 1'b1; OP_VALID = 1'b1; OP_CODE = ADD; S = 32'd7;
    @(negedge CLK);
    RESET = 1'b0; OP_VALID = 1'b0;
    m_acc = 32'd0; m_ovf = 1'b0;
    quiet = 1'b1;
    for (int j = 0; j < N + 6; j++) begin
      if (DONE || ALU_LE || !ALU_OE_n || !OP_READY) quiet = 1'b0;
      @(negedge CLK);
    end
    check("rst_prio_quiet", quiet, 1'b1);
    check("rst_prio_acc", ACC, 32'd0);

    run_op(LDN, 32'h1234_5678, 0);
    quiet = 1'b1;
    for (int j = 0; j < 5; j++) begin
      OP_CODE = 2'($urandom); S = $urandom;
      @(negedge CLK);
      if (DONE || !OP_READY || ACC !== m_acc) quiet = 1'b0;
    end
    check("no_valid_idle", quiet, 1'b1);
    run_op(NOP, $urandom, 0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0:       s = 32'h8000_0000;
        1:       s = 32'h7FFF_FFFF;
        2:       s = 32'($urandom_range(0, 3));
        default: s = $urandom;
      endcase
      run_op(2'($urandom_range(0, 3)), s, 0);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/accumulator_sequencer.md
# accumulator_sequencer

Bus-side controller and accumulator register that drives the 32-bit add/subtract ALU and consumes its latched tri-state RESULT. It accepts one arithmetic operation at a time from the control unit through a valid/ready handshake. For each operation it presents operands and SUB, waits a programmable settle time for the ripple-carry chain, pulses LE, enables OE_n, and captures the bus into the accumulator. It implements the Baby LDN/SUB datapath and exposes the sign flag used by CMP.

## Interface
- SETTLE_CYCLES, 4, cycles operands are held before LE is pulsed; legal range 1..255.

- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- OP_VALID  in  1  operation request; held stable until accepted.
- OP_READY  out  1  high when a request can be accepted.
- OP_CODE  in  2  operation: 00 = LDN (ACC = 0 − S), 01 = SUB (ACC = ACC − S), 10 = ADD (ACC = ACC + S), 11 = NOP.
- S  in  32  store operand, sampled on acceptance.
- ALU_A  out  32  ALU input A.
- ALU_B  out  32  ALU input B.
- ALU_SUB  out  1  ALU subtract control.
- ALU_LE  out  1  ALU latch enable; active high.
- ALU_OE_n  out  1  ALU output enable; active low.
- ALU_RESULT  in  32  ALU RESULT bus.
- ACC  out  32  accumulator.
- ACC_NEG  out  1  equals ACC[31].
- DONE  out  1  one-cycle completion pulse.
- OVERFLOW  out  1  sticky signed-overflow flag; see Configuration.

## Operation
- States: IDLE, SETTLE, LATCH, DRIVE, CAPTURE.
- OP_READY = (state == IDLE). It is combinational.
- **IDLE**
  - Accept on OP_VALID && OP_READY.
  - On acceptance, register ALU_A = (LDN ? 0 : ACC), ALU_B = S, ALU_SUB = (OP_CODE is LDN or SUB).
  - Load the settle counter and go to SETTLE.
  - OP_CODE 11: accept, perform no ALU cycle, stay in IDLE, assert DONE next cycle, leave ACC unchanged.
- **SETTLE**: lasts exactly SETTLE_CYCLES cycles, then go to LATCH.
- **LATCH**: ALU_LE = 1 for one cycle, then go to DRIVE.
- **DRIVE**: ALU_LE = 0, ALU_OE_n = 0 for one cycle (bus turn-on), then go to CAPTURE.
- **CAPTURE**
  - ALU_OE_n remains 0.
  - ACC <= ALU_RESULT on the closing edge; ALU_OE_n = 1 from that edge.
  - Go to IDLE with DONE = 1 for the following cycle.
- ALU_A, ALU_B and ALU_SUB are registers. They stay stable from acceptance through CAPTURE and hold their value until the next acceptance.
- All arithmetic is modulo 2^32; the carry-out is discarded.
- ALU_OE_n is 0 only in DRIVE and CAPTURE. ALU_LE is 1 only in LATCH.

## Timing
- Reset values: ACC = 0, ALU_A = 0, ALU_B = 0, ALU_SUB = 0, ALU_LE = 0, ALU_OE_n = 1, DONE = 0, OVERFLOW = 0, state = IDLE (so OP_READY = 1).
- Cycle numbering, with N = SETTLE_CYCLES:
  - Acceptance edge = cycle 0.
  - SETTLE = cycles 1..N.
  - LATCH = cycle N+1.
  - DRIVE = cycle N+2.
  - CAPTURE = cycle N+3.
  - New ACC and DONE visible in cycle N+4.
- Latency: N+4 cycles from acceptance to DONE. For NOP: 1 cycle.
- Back-to-back: the DONE cycle is an IDLE cycle, so a new op can be accepted in it. The new op's ALU_A uses the just-captured ACC.
- OP_VALID deasserted before acceptance: nothing happens.
- Reset mid-operation, in any state: the next cycle is IDLE with all reset values. The op is dropped and no DONE is issued. The ALU bus is released, so ALU_OE_n = 1.
- RESET takes priority over a simultaneous OP_VALID.

## Configuration
- ACC_OVERFLOW_EN defined: at CAPTURE, OVERFLOW is set if the result overflows as a signed 32-bit value:
  - LDN: S == 0x80000000.
  - SUB: sign(ACC) ≠ sign(S) and sign(result) ≠ sign(ACC).
  - ADD: sign(ACC) == sign(S) and sign(result) ≠ sign(ACC).
  - OVERFLOW is sticky until RESET.
- ACC_OVERFLOW_EN undefined: OVERFLOW is tied to 0 and no detection logic is built.

## Test plan
- Reset, idle 3 cycles -> ACC = 0, ALU_OE_n = 1, ALU_LE = 0, OP_READY = 1, DONE = 0.
- SETTLE_CYCLES = 4, behavioural ALU on bus, LDN S = 5 -> ALU_A = 0, ALU_B = 5, ALU_SUB = 1; ALU_LE high in cycle 5 only; ALU_OE_n low in cycles 6–7; DONE in cycle 8; ACC = 0xFFFFFFFB; ACC_NEG = 1.
- ACC = 0xFFFFFFFB, SUB S = 0xFFFFFFF6 -> ACC = 0x00000005, ACC_NEG = 0, ALU_SUB = 1.
- OP_VALID held with ADD S = 3 during the DONE cycle of the previous test -> accepted in that cycle; ALU_A = 5; ACC = 8 after 8 more cycles.
- RESET asserted in the LATCH cycle of SUB S = 1 -> next cycle IDLE, ACC = 0, ALU_OE_n = 1, ALU_LE = 0, no DONE ever issued for that op.
- LDN S = 0x80000000 -> ACC = 0x80000000, OVERFLOW = 1 with ACC_OVERFLOW_EN (stays 1 after a following ADD S = 1); OVERFLOW = 0 without it.
